// File: rtl/fec_pkg.sv
// Shared definitions for the K=7 rate-1/2 convolutional encoder: generator defaults,
// FSM state type and the generator/window parity helper.
package fec_pkg;

  localparam int K = 7;
  localparam logic [K-1:0] G1_DEFAULT = 7'o171;
  localparam logic [K-1:0] G2_DEFAULT = 7'o133;

  typedef enum logic [1:0] {
    LOAD,
    PRIME,
    ENCODE
  } conv_state_t;

  // Window w is {u_n, s1..s6}; bit 6 of g taps u_n, bit 0 taps u_{n-6}.
  function automatic logic parity7(input logic [K-1:0] g, input logic [K-1:0] w);
    return ^(g & w);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Six-stage encoder shift register (bit 5 = s1 = u_{n-1}, bit 0 = s6 = u_{n-6})
// plus the two generator parity trees evaluated on the current input bit.
module conv_enc_core
  import fec_pkg::*;
#(
  parameter logic [K-1:0] G1 = G1_DEFAULT,
  parameter logic [K-1:0] G2 = G2_DEFAULT
) (
  input  logic         clk,
  input  logic         res,
  input  logic         shift,
  input  logic         load,
  input  logic [K-2:0] load_val,
  input  logic         u,
  output logic         x,
  output logic         y
);

  logic [K-2:0] s_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let later statements see updated state.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s_q <= '0;
    end else if (load) begin
      s_q <= load_val;
    end else if (shift) begin
      s_q <= {u, s_q[K-2:1]};
    end
  end

  always_comb begin
    x = parity7(G1, {u, s_q});
    y = parity7(G2, {u, s_q});
  end

endmodule

// File: rtl/conv_encoder.sv
// Block-buffered rate-1/2 K=7 convolutional encoder with valid/ready handshakes.
// Build option: define TAIL_BITING_EN for tail-biting; default build is zero-tail.
module conv_encoder
  import fec_pkg::*;
#(
  parameter int           BLOCK_LEN = 96,
  parameter logic [K-1:0] G1        = G1_DEFAULT,
  parameter logic [K-1:0] G2        = G2_DEFAULT
) (
  input  logic clk,
  input  logic res,
  input  logic in_valid,
  input  logic d_in,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_x,
  output logic out_y,
  output logic out_last
);

`ifdef TAIL_BITING_EN
  localparam int NPAIR = BLOCK_LEN;
`else
  localparam int NPAIR = BLOCK_LEN + 6;
`endif
  localparam int CW = $clog2(BLOCK_LEN + 6);
  localparam int IW = $clog2(BLOCK_LEN);
  localparam logic [CW-1:0] LAST_IN   = CW'(BLOCK_LEN - 1);
  localparam logic [CW-1:0] LAST_PAIR = CW'(NPAIR - 1);

  conv_state_t          state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [BLOCK_LEN-1:0] blk_buf;
  logic [K-2:0]         load_val;
  logic                 u_n;
  logic                 core_x;
  logic                 core_y;
  logic                 accept;
  logic                 advance;

  assign idx     = cnt[IW-1:0];
  assign accept  = (state == LOAD) && in_valid;
  assign advance = (state == ENCODE) && out_ready;

`ifdef TAIL_BITING_EN
  assign u_n      = blk_buf[idx];
  assign load_val = blk_buf[BLOCK_LEN-1 -: K-1];
`else
  // Past the end of the block the encoder is flushed with zeros.
  assign u_n      = (cnt < CW'(BLOCK_LEN)) ? blk_buf[idx] : 1'b0;
  assign load_val = '0;
`endif

  // NOTE: the block buffer is reset on purpose so an aborted block leaves no
  // residue; it is small enough to live in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      blk_buf <= '0;
    end else if (accept) begin
      blk_buf[idx] <= d_in;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= LOAD;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (cnt == LAST_IN) begin
              cnt      <= '0;
              in_ready <= 1'b0;
              state    <= PRIME;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        PRIME: begin
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          state     <= ENCODE;
        end
        ENCODE: begin
          if (out_ready) begin
            if (cnt == LAST_PAIR) begin
              cnt       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= LOAD;
            end else begin
              cnt      <= cnt + CW'(1);
              out_last <= (cnt == LAST_PAIR - CW'(1));
            end
          end
        end
        default: begin
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          state     <= LOAD;
        end
      endcase
    end
  end

  conv_enc_core #(
    .G1(G1),
    .G2(G2)
  ) u_core (
    .clk     (clk),
    .res     (res),
    .shift   (advance),
    .load    (state == PRIME),
    .load_val(load_val),
    .u       (u_n),
    .x       (core_x),
    .y       (core_y)
  );

  assign out_x = out_valid & core_x;
  assign out_y = out_valid & core_y;

endmodule
